dircc_heat_cell: RTL and testbench

- Parametrised hardware implementation of one heat-diffusion graph device.
- Holds per-device state: time step, heat, current- and next-step accumulators, seen counters.
- Consumes weighted neighbour temperature messages and emits one (t, heat) message per time step.
- Sits between the thread's input demux and the output fanout block; one instance per device context.

---
 rtl/dircc_heat_pkg.sv | 28 ++
 rtl/dircc_heat_mac.sv | 38 +++
 rtl/dircc_heat_cell.sv | 192 +++++++++++++++++++
 tb/tb_dircc_heat_cell.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dircc_heat_pkg.sv
// Shared types and default widths for the heat-diffusion device cell.
package dircc_heat_pkg;

    localparam int T_W_DEF          = 13;
    localparam int TEMP_W_DEF       = 15;
    localparam int WEIGHT_W_DEF     = 8;
    localparam int ACC_W_DEF        = 24;
    localparam int SEEN_W_DEF       = 4;
    localparam int WEIGHT_SHIFT_DEF = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND,
        ST_RECV,
        ST_UPDATE,
        ST_DONE
    } heat_state_e;

    // Device/graph properties latched at start; field widths follow the defaults.
    typedef struct packed {
        logic [SEEN_W_DEF-1:0]   neighbour_count;
        logic [WEIGHT_W_DEF-1:0] self_weight;
        logic [TEMP_W_DEF-1:0]   init_value;
        logic                    is_dirichlet;
        logic [T_W_DEF-1:0]      max_time;
    } heat_cfg_t;

endpackage

// File: rtl/dircc_heat_mac.sv
// Combinational saturating multiply-accumulate: acc_out = sat(acc_in + weight*temp).
module dircc_heat_mac #(
    parameter int ACC_W    = 24,
    parameter int WEIGHT_W = 8,
    parameter int TEMP_W   = 15
) (
    input  logic [ACC_W-1:0]    acc_in,
    input  logic [WEIGHT_W-1:0] weight,
    input  logic [TEMP_W-1:0]   temp,
    output logic [ACC_W-1:0]    acc_out
);

    localparam int PROD_W = WEIGHT_W + TEMP_W;
    // One guard bit above the wider operand so the carry is never lost.
    localparam int SUM_W  = ((ACC_W > PROD_W) ? ACC_W : PROD_W) + 1;
    localparam logic [SUM_W-1:0] ACC_MAX = {{(SUM_W-ACC_W){1'b0}}, {ACC_W{1'b1}}};

    logic [PROD_W-1:0] prod;
    logic [SUM_W-1:0]  sum_wide;

    function automatic logic [ACC_W-1:0] sat_acc(input logic [SUM_W-1:0] v);
        logic [ACC_W-1:0] r;
        if (v > ACC_MAX) begin
            r = {ACC_W{1'b1}};
        end else begin
            r = v[ACC_W-1:0];
        end
        return r;
    endfunction

    // Widen, multiply, add and clamp to the accumulator range.
    always_comb begin
        prod     = PROD_W'(weight) * PROD_W'(temp);
        sum_wide = SUM_W'(acc_in) + SUM_W'(prod);
        acc_out  = sat_acc(sum_wide);
    end

endmodule

// File: rtl/dircc_heat_cell.sv
// One heat-diffusion device: collects weighted neighbour temperatures per
// time step, updates its heat and emits one (t, heat) message per step.
module dircc_heat_cell
    import dircc_heat_pkg::*;
#(
    parameter int T_W          = T_W_DEF,
    parameter int TEMP_W       = TEMP_W_DEF,
    parameter int WEIGHT_W     = WEIGHT_W_DEF,
    parameter int ACC_W        = ACC_W_DEF,
    parameter int SEEN_W       = SEEN_W_DEF,
    parameter int WEIGHT_SHIFT = WEIGHT_SHIFT_DEF
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic [SEEN_W-1:0]   cfg_neighbour_count,
    input  logic [WEIGHT_W-1:0] cfg_self_weight,
    input  logic [TEMP_W-1:0]   cfg_init_value,
    input  logic                cfg_is_dirichlet,
    input  logic [T_W-1:0]      cfg_max_time,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [T_W-1:0]      in_t,
    input  logic [TEMP_W-1:0]   in_temp,
    input  logic [WEIGHT_W-1:0] in_weight,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [T_W-1:0]      out_t,
    output logic [TEMP_W-1:0]   out_temp,
    output logic                done,
    output logic                err
);

    localparam logic [ACC_W-1:0] TEMP_MAX = {{(ACC_W-TEMP_W){1'b0}}, {TEMP_W{1'b1}}};

    heat_state_e       state_q, state_d;
    heat_cfg_t         cfg_q, cfg_d;
    logic [T_W-1:0]    t_q, t_d;
    logic [TEMP_W-1:0] heat_q, heat_d;
    logic [ACC_W-1:0]  acc_now_q, acc_now_d, acc_next_q, acc_next_d;
    logic [SEEN_W-1:0] seen_now_q, seen_now_d, seen_next_q, seen_next_d;
    logic              err_q, err_d;

    logic              accept, hit_now, hit_next, now_full, next_full;
    logic [T_W-1:0]    t_plus1;
    logic [ACC_W-1:0]  mac_in_acc, mac_in_sum, upd_sum, upd_scaled;
    logic [TEMP_W-1:0] heat_upd;

    function automatic logic [TEMP_W-1:0] clamp_temp(input logic [ACC_W-1:0] v);
        logic [TEMP_W-1:0] r;
        if (v > TEMP_MAX) begin
            r = {TEMP_W{1'b1}};
        end else begin
            r = v[TEMP_W-1:0];
        end
        return r;
    endfunction

    assign in_ready  = (state_q == ST_SEND) || (state_q == ST_RECV);
    assign out_valid = (state_q == ST_SEND);
    assign done      = (state_q == ST_DONE);
    assign out_t     = t_q;
    assign out_temp  = heat_q;
    assign err       = err_q;

    assign accept   = in_valid && in_ready;
    assign t_plus1  = t_q + T_W'(1);
    assign hit_now  = (in_t == t_q);
    assign hit_next = (in_t == t_plus1);
    assign now_full = (seen_now_q == cfg_q.neighbour_count);
    // The next window is also capped at the neighbour count so a carried
    // window can never overshoot the exit condition of RECV.
    assign next_full = (seen_next_q == cfg_q.neighbour_count) || (seen_next_q == {SEEN_W{1'b1}});
    assign mac_in_acc = hit_now ? acc_now_q : acc_next_q;

    dircc_heat_mac #(
        .ACC_W   (ACC_W),
        .WEIGHT_W(WEIGHT_W),
        .TEMP_W  (TEMP_W)
    ) u_mac_in (
        .acc_in (mac_in_acc),
        .weight (in_weight),
        .temp   (in_temp),
        .acc_out(mac_in_sum)
    );

    dircc_heat_mac #(
        .ACC_W   (ACC_W),
        .WEIGHT_W(WEIGHT_W),
        .TEMP_W  (TEMP_W)
    ) u_mac_upd (
        .acc_in (acc_now_q),
        .weight (cfg_q.self_weight),
        .temp   (heat_q),
        .acc_out(upd_sum)
    );

    assign upd_scaled = upd_sum >> WEIGHT_SHIFT;
    assign heat_upd   = cfg_q.is_dirichlet ? cfg_q.init_value : clamp_temp(upd_scaled);

    // Next-state: message accumulation first, then the step sequencer.
    always_comb begin
        state_d     = state_q;
        cfg_d       = cfg_q;
        t_d         = t_q;
        heat_d      = heat_q;
        acc_now_d   = acc_now_q;
        acc_next_d  = acc_next_q;
        seen_now_d  = seen_now_q;
        seen_next_d = seen_next_q;
        err_d       = err_q;

        if (accept) begin
            if (hit_now && !now_full) begin
                acc_now_d  = mac_in_sum;
                seen_now_d = seen_now_q + SEEN_W'(1);
            end else if (hit_next && !next_full) begin
                acc_next_d  = mac_in_sum;
                seen_next_d = seen_next_q + SEEN_W'(1);
            end else begin
                err_d = 1'b1;
            end
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    cfg_d = '{neighbour_count: cfg_neighbour_count,
                              self_weight:     cfg_self_weight,
                              init_value:      cfg_init_value,
                              is_dirichlet:    cfg_is_dirichlet,
                              max_time:        cfg_max_time};
                    t_d         = '0;
                    heat_d      = cfg_init_value;
                    acc_now_d   = '0;
                    acc_next_d  = '0;
                    seen_now_d  = '0;
                    seen_next_d = '0;
                    err_d       = 1'b0;
                    state_d     = ST_SEND;
                end
            end
            ST_SEND: begin
                if (out_ready) begin
                    state_d = (t_q == cfg_q.max_time) ? ST_DONE : ST_RECV;
                end
            end
            ST_RECV: begin
                // Looking at the post-accept count saves a cycle after the last input.
                if (seen_now_d == cfg_q.neighbour_count) begin
                    state_d = ST_UPDATE;
                end
            end
            ST_UPDATE: begin
                heat_d      = heat_upd;
                t_d         = t_plus1;
                acc_now_d   = acc_next_q;
                seen_now_d  = seen_next_q;
                acc_next_d  = '0;
                seen_next_d = '0;
                state_d     = ST_SEND;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any run in progress.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            cfg_q       <= '0;
            t_q         <= '0;
            heat_q      <= '0;
            acc_now_q   <= '0;
            acc_next_q  <= '0;
            seen_now_q  <= '0;
            seen_next_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cfg_q       <= cfg_d;
            t_q         <= t_d;
            heat_q      <= heat_d;
            acc_now_q   <= acc_now_d;
            acc_next_q  <= acc_next_d;
            seen_now_q  <= seen_now_d;
            seen_next_q <= seen_next_d;
            err_q       <= err_d;
        end
    end

endmodule

// File: tb/tb_dircc_heat_cell.sv
// Directed bench for dircc_heat_cell with hand-computed expected emissions.
module tb_dircc_heat_cell;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [3:0]  cfg_neighbour_count;
    logic [7:0]  cfg_self_weight;
    logic [14:0] cfg_init_value;
    logic        cfg_is_dirichlet;
    logic [12:0] cfg_max_time;
    logic        in_valid;
    logic        in_ready;
    logic [12:0] in_t;
    logic [14:0] in_temp;
    logic [7:0]  in_weight;
    logic        out_valid;
    logic        out_ready;
    logic [12:0] out_t;
    logic [14:0] out_temp;
    logic        done;
    logic        err;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;
    int last_acc_cyc = 0;

    // Emission log, written only by the monitor.
    int emit_t_a   [256];
    int emit_tmp_a [256];
    int emit_cyc_a [256];
    int total_emits = 0;
    int rd_ptr      = 0;
    int run_base    = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (reset_n && out_valid && out_ready && total_emits < 256) begin
            emit_t_a[total_emits]   <= 32'(out_t);
            emit_tmp_a[total_emits] <= 32'(out_temp);
            emit_cyc_a[total_emits] <= cyc;
            total_emits             <= total_emits + 1;
        end
    end

    dircc_heat_cell dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .start              (start),
        .cfg_neighbour_count(cfg_neighbour_count),
        .cfg_self_weight    (cfg_self_weight),
        .cfg_init_value     (cfg_init_value),
        .cfg_is_dirichlet   (cfg_is_dirichlet),
        .cfg_max_time       (cfg_max_time),
        .in_valid           (in_valid),
        .in_ready           (in_ready),
        .in_t               (in_t),
        .in_temp            (in_temp),
        .in_weight          (in_weight),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
        .out_t              (out_t),
        .out_temp           (out_temp),
        .done               (done),
        .err                (err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int cnt, input int selfw, input int init, input int dir, input int maxt);
        @(posedge clk);
        #1;
        cfg_neighbour_count = 4'(cnt);
        cfg_self_weight     = 8'(selfw);
        cfg_init_value      = 15'(init);
        cfg_is_dirichlet    = 1'(dir);
        cfg_max_time        = 13'(maxt);
        start               = 1'b1;
        rd_ptr              = total_emits;
        run_base            = total_emits;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic send_msg(input string tag, input int t, input int temp, input int w);
        logic ok;
        ok        = 1'b0;
        in_t      = 13'(t);
        in_temp   = 15'(temp);
        in_weight = 8'(w);
        in_valid  = 1'b1;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) begin
                last_acc_cyc = cyc;
                @(posedge clk);
                #1;
                ok = 1'b1;
            end
        end
        in_valid = 1'b0;
        chk({tag, "_accept"}, 32'(ok), 1);
    endtask

    task automatic expect_emit(input string tag, input int et, input int etemp, output int ecyc);
        logic have;
        ecyc = -1;
        for (int i = 0; i < 300 && rd_ptr >= total_emits; i++) @(posedge clk);
        #1;
        have = (rd_ptr < total_emits);
        chk({tag, "_seen"}, 32'(have), 1);
        if (have) begin
            chk({tag, "_t"}, emit_t_a[rd_ptr], et);
            chk({tag, "_temp"}, emit_tmp_a[rd_ptr], etemp);
            ecyc = emit_cyc_a[rd_ptr];
            rd_ptr++;
        end
    endtask

    initial begin
        int ec;
        reset_n = 1'b0;
        start = 1'b0;
        cfg_neighbour_count = '0;
        cfg_self_weight = '0;
        cfg_init_value = '0;
        cfg_is_dirichlet = 1'b0;
        cfg_max_time = '0;
        in_valid = 1'b0;
        in_t = '0;
        in_temp = '0;
        in_weight = '0;
        out_ready = 1'b1;

        // Reset state
        #23;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_out_t", 32'(out_t), 0);
        chk("rst_out_temp", 32'(out_temp), 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        wait_cycles(2);
        chk("idle_in_ready", 32'(in_ready), 0);

        // Run A: plain averaging, latency, run to done
        do_start(4, 0, 0, 0, 2);
        expect_emit("a0", 0, 0, ec);
        for (int i = 0; i < 4; i++) send_msg("a_t0", 0, 10, 1);
        expect_emit("a1", 1, 10, ec);
        chk("a_latency", ec - last_acc_cyc, 2);
        for (int i = 0; i < 4; i++) send_msg("a_t1", 1, 20, 1);
        expect_emit("a2", 2, 20, ec);
        wait_cycles(3);
        chk("a_done", 32'(done), 1);
        chk("a_done_out_valid", 32'(out_valid), 0);
        chk("a_done_in_ready", 32'(in_ready), 0);
        chk("a_count", total_emits - run_base, 3);
        chk("a_err", 32'(err), 0);

        // Run B: restart from DONE, interleaved current/next-step messages
        do_start(4, 0, 0, 0, 2);
        chk("b_done_clr", 32'(done), 0);
        expect_emit("b0", 0, 0, ec);
        send_msg("b_m0", 0, 10, 1);
        send_msg("b_m1", 0, 10, 1);
        send_msg("b_m2", 1, 20, 1);
        send_msg("b_m3", 0, 10, 1);
        send_msg("b_m4", 0, 10, 1);
        expect_emit("b1", 1, 10, ec);
        for (int i = 0; i < 3; i++) send_msg("b_t1", 1, 20, 1);
        expect_emit("b2", 2, 20, ec);
        wait_cycles(3);
        chk("b_done", 32'(done), 1);

        // Run C: Dirichlet cell keeps its initial value
        do_start(1, 3, 10, 1, 3);
        for (int t = 0; t < 4; t++) begin
            expect_emit("c_emit", t, 10, ec);
            if (t < 3) send_msg("c_in", t, 0, 1);
        end
        wait_cycles(10);
        chk("c_done", 32'(done), 1);
        chk("c_count", total_emits - run_base, 4);

        // Run D: carried window, full-window drop, output stall
        do_start(2, 4, 100, 0, 3);
        chk("d_err0", 32'(err), 0);
        expect_emit("d0", 0, 100, ec);
        send_msg("d_n0", 1, 40, 1);
        send_msg("d_n1", 1, 40, 1);
        out_ready = 1'b0;
        send_msg("d_c0", 0, 20, 2);
        send_msg("d_c1", 0, 20, 2);
        send_msg("d_full", 1, 1000, 255);
        chk("d_err_full", 32'(err), 1);
        send_msg("d_s0", 2, 4, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("d_stall_valid", 32'(out_valid), 1);
            chk("d_stall_t", 32'(out_t), 1);
            chk("d_stall_temp", 32'(out_temp), 120);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        expect_emit("d1", 1, 120, ec);
        expect_emit("d2", 2, 140, ec);
        send_msg("d_s1", 2, 4, 1);
        expect_emit("d3", 3, 142, ec);
        wait_cycles(3);
        chk("d_done", 32'(done), 1);

        // Run F: heat clamps at the temperature ceiling
        do_start(1, 0, 0, 0, 1);
        expect_emit("f0", 0, 0, ec);
        send_msg("f_in", 0, 32767, 255);
        expect_emit("f1", 1, 32767, ec);

        // Run G: no neighbours, heat driven by self weight alone
        do_start(0, 8, 7, 0, 2);
        expect_emit("g0", 0, 7, ec);
        expect_emit("g1", 1, 14, ec);
        expect_emit("g2", 2, 28, ec);

        // Run E: out-of-window drop, then reset in RECV
        do_start(4, 0, 0, 0, 2);
        chk("e_err0", 32'(err), 0);
        expect_emit("e0", 0, 0, ec);
        send_msg("e_far", 2, 500, 9);
        chk("e_err_far", 32'(err), 1);
        for (int i = 0; i < 4; i++) send_msg("e_t0", 0, 10, 1);
        expect_emit("e1", 1, 10, ec);
        send_msg("e_t1", 1, 20, 1);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("e_rst_out_valid", 32'(out_valid), 0);
        chk("e_rst_in_ready", 32'(in_ready), 0);
        chk("e_rst_err", 32'(err), 0);
        chk("e_rst_done", 32'(done), 0);
        chk("e_rst_out_t", 32'(out_t), 0);
        chk("e_rst_out_temp", 32'(out_temp), 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        wait_cycles(3);
        chk("e_idle_in_ready", 32'(in_ready), 0);
        chk("e_idle_out_valid", 32'(out_valid), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
